instr_fetch_unit: RTL and testbench

//  Fetch-side initiator for the word-aligned, combinational-read instruction memory.

---
 rtl/rv32i_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/instr_fetch_unit.sv | 67 ++++++
 tb/tb_instr_fetch_unit.sv | 135 +++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared datapath width, NOP encoding and fetch entry layout
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small registered prefetch queue with synchronous reset and flush
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  entry_t        wdata,
    input  logic          pop,
    output entry_t        rdata,
    output logic [CW-1:0] count
);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

    // Pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // Control state: reset and flush both empty the queue
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by count alone
    always_ff @(posedge clk) begin
        if (push && !flush && !reset)
            mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch PC owner feeding decode through a prefetch FIFO
module instr_fetch_unit #(
    parameter int              XLEN       = rv32i_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc
);

    import rv32i_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   count;
    logic            push, pop;
    fetch_entry_t    wdata, head;
    logic            unused_redirect_lo;

    assign imem_addr          = fetch_pc_q;
    assign if_valid           = count != '0;
    assign pop                = if_valid & if_ready;
    assign push               = !redirect_valid & ((count < CW'(FIFO_DEPTH)) | pop);
    assign wdata              = '{pc: fetch_pc_q, instr: imem_instr};
    assign if_instr           = if_valid ? head.instr : NOP_INSTR;
    assign if_pc              = if_valid ? head.pc : '0;
    assign unused_redirect_lo = ^redirect_pc[1:0];

    // Redirect wins over sequential advance; misaligned target bits are dropped
    always_comb begin
        fetch_pc_d = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00}
                   : push           ? fetch_pc_q + XLEN'(4)
                   :                  fetch_pc_q;
    end

    // Fetch PC register
    always_ff @(posedge clk) begin
        if (reset)
            fetch_pc_q <= {RESET_PC[XLEN-1:2], 2'b00};
        else
            fetch_pc_q <= fetch_pc_d;
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed table-driven check of the fetch unit
module tb_instr_fetch_unit;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        chk;
        logic        v;
        logic [31:0] pc;
        logic [31:0] addr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr, imem_instr, redirect_pc, if_instr, if_pc;
    logic        redirect_valid, if_valid, if_ready;
    logic [31:0] imem_addr2, imem_instr2, if_instr2, if_pc2;
    logic        if_valid2;
    int          total = 0;
    int          bad = 0;
    vec_t        vt [33];

    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return {8'hA5, a[25:2]};
    endfunction

    assign imem_instr  = tag(imem_addr);
    assign imem_instr2 = tag(imem_addr2);

    instr_fetch_unit u_dut (
        .clk(clk), .reset(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (
        .clk(clk), .reset(rst), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .if_valid(if_valid2), .if_ready(1'b1), .if_instr(if_instr2), .if_pc(if_pc2)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b1;
        vt[0]  = '{1, 1, 0, 0,     0, 0, 0,     0};
        vt[1]  = '{1, 1, 0, 0,     1, 0, 0,     0};
        vt[2]  = '{0, 1, 0, 0,     1, 0, 0,     0};
        vt[3]  = '{0, 1, 0, 0,     1, 1, 0,     4};
        vt[4]  = '{0, 1, 0, 0,     1, 1, 4,     8};
        vt[5]  = '{0, 1, 0, 0,     1, 1, 8,     'hC};
        vt[6]  = '{1, 0, 0, 0,     1, 1, 'hC,   'h10};
        vt[7]  = '{0, 0, 0, 0,     1, 0, 0,     0};
        vt[8]  = '{0, 0, 0, 0,     1, 1, 0,     4};
        vt[9]  = '{0, 0, 0, 0,     1, 1, 0,     8};
        vt[10] = '{0, 0, 0, 0,     1, 1, 0,     8};
        vt[11] = '{0, 0, 0, 0,     1, 1, 0,     8};
        vt[12] = '{0, 0, 0, 0,     1, 1, 0,     8};
        vt[13] = '{0, 1, 0, 0,     1, 1, 0,     8};
        vt[14] = '{0, 1, 0, 0,     1, 1, 4,     'hC};
        vt[15] = '{0, 1, 0, 0,     1, 1, 8,     'h10};
        vt[16] = '{0, 1, 0, 0,     1, 1, 'hC,   'h14};
        vt[17] = '{0, 0, 0, 0,     1, 1, 'h10,  'h18};
        vt[18] = '{0, 0, 1, 'h40,  1, 1, 'h10,  'h18};
        vt[19] = '{0, 1, 0, 0,     1, 0, 0,     'h40};
        vt[20] = '{0, 1, 0, 0,     1, 1, 'h40,  'h44};
        vt[21] = '{0, 1, 1, 'h43,  1, 1, 'h44,  'h48};
        vt[22] = '{0, 1, 0, 0,     1, 0, 0,     'h40};
        vt[23] = '{0, 1, 1, 'h20,  1, 1, 'h40,  'h44};
        vt[24] = '{0, 1, 1, 'h60,  1, 0, 0,     'h20};
        vt[25] = '{0, 1, 0, 0,     1, 0, 0,     'h60};
        vt[26] = '{0, 1, 0, 0,     1, 1, 'h60,  'h64};
        vt[27] = '{0, 0, 0, 0,     1, 1, 'h64,  'h68};
        vt[28] = '{0, 0, 0, 0,     1, 1, 'h64,  'h6C};
        vt[29] = '{1, 0, 0, 0,     1, 1, 'h64,  'h6C};
        vt[30] = '{0, 1, 0, 0,     1, 0, 0,     0};
        vt[31] = '{0, 1, 0, 0,     1, 1, 0,     4};
        vt[32] = '{0, 1, 0, 0,     1, 1, 4,     8};
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            rst            = vt[i].rst;
            if_ready       = vt[i].rdy;
            redirect_valid = vt[i].redir;
            redirect_pc    = vt[i].rpc;
            #1;
            if (vt[i].chk) begin
                check($sformatf("row%0d valid", i), {31'b0, if_valid}, {31'b0, vt[i].v});
                check($sformatf("row%0d pc", i), if_pc, vt[i].pc);
                check($sformatf("row%0d instr", i), if_instr, vt[i].v ? tag(vt[i].pc) : 32'h0000_0013);
                check($sformatf("row%0d addr", i), imem_addr, vt[i].addr);
            end
        end
        @(negedge clk);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("wrap first valid", {31'b0, if_valid2}, 32'h0);
        check("wrap first addr", imem_addr2, 32'hFFFF_FFF8);
        begin
            int n = 0;
            while (!if_valid2 && n < 4) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("wrap valid wait", {31'b0, if_valid2}, 32'h1);
            check("wrap latency", n, 1);
        end
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'hFFFF_FFF8 + 32'(4 * k);
            check($sformatf("wrap pc%0d", k), if_pc2, exp_pc);
            check($sformatf("wrap instr%0d", k), if_instr2, tag(exp_pc));
            @(negedge clk);
            #1;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
